// File: rtl/register_transfer_controller_if.sv
// Command/response handshake and register-file bus bundle for register_transfer_controller.
// master = the controller, slave = control unit plus register file.
interface register_transfer_controller_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [SEL_WIDTH-1:0]  cmd_src;
  logic [SEL_WIDTH-1:0]  cmd_dst;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;
  logic                  register_enable;
  logic                  read_write;
  logic [SEL_WIDTH-1:0]  register_select;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [DATA_WIDTH-1:0] bus_rdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_data, bus_rdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
           register_enable, read_write, register_select, bus_wdata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_data, bus_rdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
           register_enable, read_write, register_select, bus_wdata
  );
endinterface

// File: rtl/register_transfer_controller.sv
// Register-file bus initiator: runs READ/WRITE/MOVE (and SWAP when RTC_SWAP_EN is defined)
// as strobe sequences on the 4-register file and returns one response pulse per command.
module register_transfer_controller #(
  parameter int DATA_WIDTH   = 8,
  parameter int SEL_WIDTH    = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  register_transfer_controller_if.master bus
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SWAP  = 2'b11;
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);

`ifdef RTC_SWAP_EN
  typedef enum logic [2:0] {IDLE, RD1, RW1, RD2, RW2, WR1, WR2} state_e;
`else
  typedef enum logic [2:0] {IDLE, RD1, RW1, WR1} state_e;
`endif

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            op_q, op_d;
  logic [SEL_WIDTH-1:0]  src_q, src_d, dst_q, dst_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, t0_q, t0_d;
`ifdef RTC_SWAP_EN
  logic [DATA_WIDTH-1:0] t1_q, t1_d;
`endif
  logic                  en_q, en_d, rw_q, rw_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rvld_q, rvld_d, rerr_q, rerr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  accept;

  assign bus.cmd_ready       = (state_q == IDLE) && !reset;
  assign accept              = bus.cmd_valid && bus.cmd_ready;
  assign bus.register_enable = en_q;
  assign bus.read_write      = rw_q;
  assign bus.register_select = sel_q;
  assign bus.bus_wdata       = wdata_q;
  assign bus.rsp_valid       = rvld_q;
  assign bus.rsp_data        = rdata_q;
  assign bus.rsp_err         = rerr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    t0_d    = t0_q;
`ifdef RTC_SWAP_EN
    t1_d    = t1_q;
`endif
    rvld_d  = 1'b0;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    en_d    = 1'b0;
    rw_d    = 1'b1;
    sel_d   = '0;
    wdata_d = '0;

    case (state_q)
      IDLE: if (accept) begin
        op_d   = bus.cmd_op;
        src_d  = bus.cmd_src;
        dst_d  = bus.cmd_dst;
        data_d = bus.cmd_data;
        case (bus.cmd_op)
          OP_WRITE: state_d = WR1;
`ifdef RTC_SWAP_EN
          OP_SWAP:  state_d = RD1;
`else
          OP_SWAP: begin
            rvld_d  = 1'b1;
            rerr_d  = 1'b1;
            rdata_d = '0;
          end
`endif
          default:  state_d = RD1;
        endcase
      end
      RD1: begin
        state_d = RW1;
        cnt_d   = '0;
      end
      RW1: if (cnt_q == CNT_LAST) begin
        t0_d = bus.bus_rdata;
        if (op_q == OP_READ) begin
          state_d = IDLE;
          rvld_d  = 1'b1;
          rerr_d  = 1'b0;
          rdata_d = bus.bus_rdata;
        end
`ifdef RTC_SWAP_EN
        else if (op_q == OP_SWAP) state_d = RD2;
`endif
        else state_d = WR1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
`ifdef RTC_SWAP_EN
      RD2: begin
        state_d = RW2;
        cnt_d   = '0;
      end
      RW2: if (cnt_q == CNT_LAST) begin
        t1_d    = bus.bus_rdata;
        state_d = WR1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      WR2: begin
        state_d = IDLE;
        rvld_d  = 1'b1;
        rerr_d  = 1'b0;
        rdata_d = t0_q;
      end
`endif
      WR1: begin
`ifdef RTC_SWAP_EN
        if (op_q == OP_SWAP) state_d = WR2;
        else
`endif
        begin
          state_d = IDLE;
          rvld_d  = 1'b1;
          rerr_d  = 1'b0;
          rdata_d = (op_q == OP_WRITE) ? data_q : t0_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus strobes are registered, so they are decoded from the state being entered.
    case (state_d)
      RD1: begin
        en_d  = 1'b1;
        sel_d = src_d;
      end
      WR1: begin
        en_d    = 1'b1;
        rw_d    = 1'b0;
        sel_d   = dst_d;
        wdata_d = (op_d == OP_WRITE) ? data_d : t0_d;
      end
`ifdef RTC_SWAP_EN
      RD2: begin
        en_d  = 1'b1;
        sel_d = dst_d;
      end
      WR2: begin
        en_d    = 1'b1;
        rw_d    = 1'b0;
        sel_d   = src_d;
        wdata_d = t1_d;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      t0_q    <= '0;
`ifdef RTC_SWAP_EN
      t1_q    <= '0;
`endif
      en_q    <= 1'b0;
      rw_q    <= 1'b1;
      sel_q   <= '0;
      wdata_q <= '0;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      t0_q    <= t0_d;
`ifdef RTC_SWAP_EN
      t1_q    <= t1_d;
`endif
      en_q    <= en_d;
      rw_q    <= rw_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

endmodule

// File: tb/tb_register_transfer_controller.sv
// Bench for register_transfer_controller: directed test-plan commands plus random commands,
// checked against an array model of the register file and per-opcode strobe/latency rules.
module tb_register_transfer_controller;
  localparam int DW = 8;
  localparam int SW = 2;
  localparam int L  = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  register_transfer_controller_if #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

  register_transfer_controller #(.DATA_WIDTH(DW), .SEL_WIDTH(SW), .READ_LATENCY(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Register file attached to the bus; read data is held until the next read strobe.
  logic [7:0] rf [4];
  logic [7:0] rd_q;
  logic       rf_init = 1'b0;
  always @(posedge clk) begin
    if (!rf_init) begin
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
      rd_q    <= 8'h00;
      rf_init <= 1'b1;
    end else if (bus.register_enable) begin
      if (bus.read_write) rd_q <= rf[bus.register_select];
      else rf[bus.register_select] <= bus.bus_wdata;
    end
  end
  assign bus.bus_rdata = rd_q;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mdl [4];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [18:0] stb(int cyc, logic rw, logic [1:0] sel, logic [7:0] d);
    return {8'(cyc), rw, sel, (rw ? 8'h00 : d)};
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                         input logic [7:0] d);
    logic [18:0] exp_q[$];
    logic [18:0] got_q[$];
    int          exp_lat, lat, idle_bad, rdy_bad;
    logic [7:0]  exp_data, a, b, obs_data;
    logic        exp_err, obs_err;
    exp_err = 1'b0; a = mdl[src]; b = mdl[dst];
    lat = 0; idle_bad = 0; rdy_bad = 0; obs_data = 'x; obs_err = 'x;
    case (op)
      2'd0: begin exp_q.push_back(stb(1, 1, src, 0)); exp_lat = 2 + L; exp_data = a; end
      2'd1: begin exp_q.push_back(stb(1, 0, dst, d)); exp_lat = 2; exp_data = d; mdl[dst] = d; end
      2'd2: begin
        exp_q.push_back(stb(1, 1, src, 0));
        exp_q.push_back(stb(2 + L, 0, dst, a));
        exp_lat = 3 + L; exp_data = a; mdl[dst] = a;
      end
      default: begin
`ifdef RTC_SWAP_EN
        exp_q.push_back(stb(1, 1, src, 0));
        exp_q.push_back(stb(2 + L, 1, dst, 0));
        exp_q.push_back(stb(3 + 2 * L, 0, dst, a));
        exp_q.push_back(stb(4 + 2 * L, 0, src, b));
        exp_lat = 5 + 2 * L; exp_data = a; mdl[dst] = a; mdl[src] = b;
`else
        exp_lat = 1; exp_data = 8'h00; exp_err = 1'b1;
`endif
      end
    endcase

    for (int i = 0; i < 50 && !bus.cmd_ready; i++) tick();
    check_eq("cmd_ready_before_issue", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_src = src; bus.cmd_dst = dst; bus.cmd_data = d;
    tick();
    // Scramble the command inputs to catch fields that are not latched at acceptance.
    bus.cmd_valid = 1'b0;
    bus.cmd_src = 2'($urandom); bus.cmd_dst = 2'($urandom); bus.cmd_data = 8'($urandom);
    for (int k = 1; k <= 40; k++) begin
      if (bus.register_enable)
        got_q.push_back(stb(k, bus.read_write, bus.register_select, bus.bus_wdata));
      else if (bus.read_write !== 1'b1 || bus.register_select !== 2'd0 || bus.bus_wdata !== 8'd0)
        idle_bad++;
      if (bus.rsp_valid) begin
        lat = k; obs_data = bus.rsp_data; obs_err = bus.rsp_err;
        break;
      end
      if (bus.cmd_ready) rdy_bad++;
      tick();
    end
    check_eq($sformatf("op%0d.latency", op), lat, exp_lat);
    check_eq($sformatf("op%0d.rsp_data", op), obs_data, exp_data);
    check_eq($sformatf("op%0d.rsp_err", op), obs_err, exp_err);
    check_eq($sformatf("op%0d.strobe_count", op), got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("op%0d.strobe%0d", op, i), got_q[i], exp_q[i]);
    check_eq($sformatf("op%0d.idle_bus", op), idle_bad, 0);
    check_eq($sformatf("op%0d.ready_while_busy", op), rdy_bad, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_src = 2'd0; bus.cmd_dst = 2'd0; bus.cmd_data = 8'd0;
    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
    repeat (3) tick();
    check_eq("rst.cmd_ready", bus.cmd_ready, 0);
    check_eq("rst.rsp_valid", bus.rsp_valid, 0);
    check_eq("rst.rsp_data", bus.rsp_data, 0);
    check_eq("rst.rsp_err", bus.rsp_err, 0);
    check_eq("rst.enable", bus.register_enable, 0);
    check_eq("rst.read_write", bus.read_write, 1);
    check_eq("rst.select", bus.register_select, 0);
    check_eq("rst.wdata", bus.bus_wdata, 0);
    reset = 1'b0;
    tick();

    run_cmd(2'd1, 2'd0, 2'd2, 8'h0F);
    run_cmd(2'd0, 2'd2, 2'd0, 8'h00);
    run_cmd(2'd2, 2'd2, 2'd3, 8'h00);
    run_cmd(2'd0, 2'd3, 2'd0, 8'h00);
    run_cmd(2'd1, 2'd0, 2'd0, 8'hA5);
    run_cmd(2'd1, 2'd0, 2'd1, 8'h3C);
    run_cmd(2'd3, 2'd0, 2'd1, 8'h00);
    run_cmd(2'd0, 2'd0, 2'd0, 8'h00);
    run_cmd(2'd0, 2'd1, 2'd0, 8'h00);
    run_cmd(2'd2, 2'd1, 2'd1, 8'h00);
    run_cmd(2'd3, 2'd2, 2'd2, 8'h00);

    // Back-to-back: a WRITE held valid through the READ's response cycle.
    for (int i = 0; i < 50 && !bus.cmd_ready; i++) tick();
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_src = 2'd2;
    tick();
    bus.cmd_op = 2'd1; bus.cmd_dst = 2'd1; bus.cmd_data = 8'h5A;
    for (int k = 1; k < 2 + L; k++) begin
      check_eq("b2b.ready_busy", bus.cmd_ready, 0);
      check_eq("b2b.no_early_rsp", bus.rsp_valid, 0);
      tick();
    end
    check_eq("b2b.read_rsp", bus.rsp_valid, 1);
    check_eq("b2b.read_data", bus.rsp_data, mdl[2]);
    check_eq("b2b.ready_in_rsp", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    check_eq("b2b.wr_enable", bus.register_enable, 1);
    check_eq("b2b.wr_rw", bus.read_write, 0);
    check_eq("b2b.wr_sel", bus.register_select, 1);
    check_eq("b2b.wr_data", bus.bus_wdata, 8'h5A);
    tick();
    check_eq("b2b.wr_rsp", bus.rsp_valid, 1);
    check_eq("b2b.wr_rsp_data", bus.rsp_data, 8'h5A);
    mdl[1] = 8'h5A;

    // Reset during cycle 2 of a MOVE 0 -> 3, with a WRITE presented while reset is high.
    run_cmd(2'd1, 2'd0, 2'd3, 8'hC3);
    for (int i = 0; i < 50 && !bus.cmd_ready; i++) tick();
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2; bus.cmd_src = 2'd0; bus.cmd_dst = 2'd3;
    tick();
    bus.cmd_valid = 1'b0;
    check_eq("rstmid.read_strobe", bus.register_enable, 1);
    tick();
    reset = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_dst = 2'd0; bus.cmd_data = 8'h77;
    #1;
    check_eq("rstmid.ready_in_reset", bus.cmd_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    check_eq("rstmid.ready_after", bus.cmd_ready, 1);
    check_eq("rstmid.rw_idle", bus.read_write, 1);
    for (int k = 0; k < 6; k++) begin
      check_eq("rstmid.no_strobe", bus.register_enable, 0);
      check_eq("rstmid.no_rsp", bus.rsp_valid, 0);
      tick();
    end
    run_cmd(2'd0, 2'd3, 2'd0, 8'h00);
    run_cmd(2'd0, 2'd0, 2'd0, 8'h00);

    for (int n = 0; n < 80; n++)
      run_cmd(2'($urandom_range(0, 3)), 2'($urandom), 2'($urandom), 8'($urandom));

    tick();
    for (int i = 0; i < 4; i++) check_eq($sformatf("final.R%0d", i), rf[i], mdl[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/register_transfer_controller.md
# register_transfer_controller

Bus initiator for the 4 x 8-bit register file in the 8-bit microprocessor. Accepts one register command at a time from the control unit (read, write, move, optional swap) through a valid/ready handshake. Sequences the register file's enable / read_write / select / data strobes to carry out the command, then returns one response pulse with the resulting data. This block is the driving end of the register-file bus: it sits between the control unit and the register file.

## Interface
- DATA_WIDTH, 8, register and bus data width
- SEL_WIDTH, 2, register select width (4 registers)
- READ_LATENCY, 1, idle bus cycles after a read strobe; read data is sampled at the clock edge ending the last of these cycles (must be >= 1)

- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller idle and able to accept a command
- cmd_op  in  2  00 READ, 01 WRITE, 10 MOVE, 11 SWAP
- cmd_src  in  SEL_WIDTH  source register (READ, MOVE, SWAP)
- cmd_dst  in  SEL_WIDTH  destination register (WRITE, MOVE, SWAP)
- cmd_data  in  DATA_WIDTH  write data (WRITE only)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  DATA_WIDTH  result data, valid with rsp_valid
- rsp_err  out  1  unsupported opcode, valid with rsp_valid
- register_enable  out  1  register file strobe
- read_write  out  1  1 = read, 0 = write
- register_select  out  SEL_WIDTH  addressed register
- bus_wdata  out  DATA_WIDTH  to register file data_bus_in
- bus_rdata  in  DATA_WIDTH  from register file data_bus_out

## Operation
- A command is accepted on a rising edge where cmd_valid && cmd_ready. cmd_ready = 1 only in IDLE and only when reset is low. Command fields are latched at acceptance.
- Idle bus values: register_enable=0, read_write=1, register_select=0, bus_wdata=0.
- Read strobe: enable=1, rw=1, sel=reg for one cycle, then READ_LATENCY idle cycles, then capture bus_rdata.
- Write strobe: enable=1, rw=0, sel=reg, bus_wdata=data for one cycle.
- FSM states: IDLE, RD1, RW1 (read wait), RD2, RW2, WR1, WR2.
- READ: RD1(src) -> RW1 -> IDLE. rsp_data = captured value.
- WRITE: WR1(dst, cmd_data) -> IDLE. rsp_data = cmd_data.
- MOVE: RD1(src) -> RW1 -> WR1(dst, T0) -> IDLE. rsp_data = T0.
- SWAP: RD1(src) -> RW1 (T0) -> RD2(dst) -> RW2 (T1) -> WR1(dst, T0) -> WR2(src, T1) -> IDLE. rsp_data = T0, the original src value.
- rsp_valid pulses for exactly one cycle, in the cycle the FSM re-enters IDLE. cmd_ready is also 1 in that cycle, so back-to-back commands are allowed. There is no response backpressure.
- src == dst: the full sequence is still performed; MOVE and SWAP leave the register value unchanged.
- rsp_err = 0 for every supported opcode.

## Timing
- Cycle numbering: cycle 0 is the acceptance cycle; the first strobe is in cycle 1. L = READ_LATENCY.
- rsp_valid cycle: WRITE 2; READ 2+L; MOVE 3+L; SWAP 5+2L. With L=1 this gives 2, 3, 4, 7.
- All outputs are registered.
- Reset values: state IDLE, cmd_ready=0 while reset is high, rsp_valid=0, rsp_data=0, rsp_err=0, register_enable=0, read_write=1, register_select=0, bus_wdata=0, T0=T1=0.
- Reset asserted mid-command: the command is aborted. The bus returns to idle values on the edge that samples reset, and no rsp_valid is produced. Any write strobe already issued is not undone.
- A command presented while reset is high is ignored.

## Configuration
- RTC_SWAP_EN defined: SWAP is supported as described above.
- RTC_SWAP_EN undefined: the SWAP states are not built.
  - Opcode 11 is still accepted but causes no bus activity.
  - rsp_valid pulses in cycle 1 with rsp_err=1 and rsp_data=0.

## Test plan
- WRITE dst=2, data=0x0F -> cycle 1: enable=1, rw=0, sel=2, bus_wdata=0x0F. Cycle 2: rsp_valid=1, rsp_data=0x0F.
- READ src=2 after the write above, L=1 -> read strobe in cycle 1; rsp_valid in cycle 3 with rsp_data=0x0F. cmd_ready=0 in cycles 1-2.
- MOVE src=2, dst=3 with R2=0x0F -> read of R2, then write of 0x0F to sel=3 in cycle 3; rsp in cycle 4. A following READ src=3 returns 0x0F.
- SWAP src=0 (0xA5), dst=1 (0x3C), RTC_SWAP_EN defined -> rsp in cycle 7 with rsp_data=0xA5; readback gives R0=0x3C, R1=0xA5. Same command without the macro -> rsp in cycle 1, rsp_err=1, no strobes.
- Back-to-back: WRITE held valid across a READ's response cycle -> WRITE accepted in the READ's rsp_valid cycle; its strobe appears in the next cycle.
- Reset asserted in cycle 2 of a MOVE -> no write strobe, no rsp_valid. cmd_ready=1 in the first cycle after reset deasserts; bus stays at idle values.
